mux_8to1_rr_merge: RTL and testbench

//  - Merges eight valid/ready input channels into one output stream; transmit-side counterpart of the 1:8 demux.
//  - Each output beat carries its source index on out_sel[2:0], which drives the far-end demux S input directly.
//  - Round-robin arbitration with a single registered output stage; sits upstream of a shared link.

---
 rtl/mux_merge_pkg.sv | 6 +
 rtl/rr_arb_8.sv | 37 +++
 rtl/mux_8to1_rr_merge.sv | 63 ++++++
 tb/tb_mux_8to1_rr_merge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_merge_pkg.sv
// Shared constants and the channel-index type for the 8:1 round-robin merge.
package mux_merge_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  typedef logic [SEL_W-1:0] ch_idx_t;
endpackage

// File: rtl/rr_arb_8.sv
// Combinational 8-way round-robin arbiter: rotate requests by ptr, pick the lowest, rotate back.
module rr_arb_8
  import mux_merge_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         ptr,
  input  logic            en,
  output logic [N_CH-1:0] gnt,
  output ch_idx_t         gnt_idx,
  output logic            gnt_vld
);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  ch_idx_t           off;
  logic              found;

  // req_rot[0] is the request at ptr, req_rot[1] the one after it, and so on.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[N_CH-1:0];

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off   = ch_idx_t'(i);
        found = 1'b1;
      end
    end
  end

  assign gnt_idx = ptr + off;
  assign gnt_vld = en & found;
  assign gnt     = gnt_vld ? (N_CH'(1) << gnt_idx) : '0;

endmodule

// File: rtl/mux_8to1_rr_merge.sv
// Merges eight valid/ready channels into one registered stream tagged with its source index.
module mux_8to1_rr_merge
  import mux_merge_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  // Handshake: a beat moves on any side exactly when valid and ready are both high
  // at the rising edge; valid never depends on ready, and the output holds while stalled.
  logic              load_en;
  logic [N_CH-1:0]   gnt;
  ch_idx_t           gnt_idx;
  logic              gnt_vld;
  ch_idx_t           rr_ptr;
  logic [DATA_W-1:0] gnt_data;

  assign load_en = ~out_valid | out_ready;

  rr_arb_8 u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .en      (load_en & rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign in_ready = gnt;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == ch_idx_t'(i)) gnt_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (gnt_vld) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt_idx;
      rr_ptr    <= gnt_idx + 3'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_8to1_rr_merge.sv
// Self-checking bench for mux_8to1_rr_merge: table of grant vectors plus corner-case sequences.
module tb_mux_8to1_rr_merge;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  int   m_ptr;
  logic m_ov;
  logic [10:0] exp_q[$];

  typedef struct {
    logic [7:0] valid;
    logic [7:0] exp_rdy;
  } vec_t;

  vec_t vecs[9];

  mux_8to1_rr_merge #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ov  = 1'b0;
    m_ptr = 0;
    exp_q.delete();
  endtask

  // One clock: check at the falling edge against the model, then advance to posedge+1.
  task automatic step();
    logic [7:0] exp_rdy;
    logic hit;
    int g;
    @(negedge clk);
    exp_rdy = '0;
    hit = 1'b0;
    g = 0;
    if (rst_n && (!m_ov || out_ready)) begin
      for (int j = 0; j < 8; j++) begin
        int k;
        k = (m_ptr + j) % 8;
        if (!hit && in_valid[k]) begin
          hit = 1'b1;
          g = k;
        end
      end
    end
    if (hit) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: got sel %0d data %0h expected no beat", out_sel, out_data);
      end else begin
        if ({out_sel, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL out_beat: got sel %0d data %0h expected sel %0d data %0h",
                   out_sel, out_data, exp_q[0][10:8], exp_q[0][7:0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (!rst_n) model_reset();
    else if (hit) begin
      exp_q.push_back({3'(g), in_data[g*8 +: 8]});
      m_ov  = 1'b1;
      m_ptr = (g + 1) % 8;
    end else if (out_ready) m_ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    in_data = {$urandom(), $urandom()};
  endtask

  initial begin
    vecs[0] = '{8'h20, 8'h20};
    vecs[1] = '{8'h21, 8'h01};
    vecs[2] = '{8'h81, 8'h80};
    vecs[3] = '{8'h81, 8'h01};
    vecs[4] = '{8'h00, 8'h00};
    vecs[5] = '{8'hFF, 8'h02};
    vecs[6] = '{8'h0C, 8'h04};
    vecs[7] = '{8'h0C, 8'h08};
    vecs[8] = '{8'h0C, 8'h04};

    // Reset with every channel requesting.
    rst_n = 1'b0;
    in_valid = 8'hFF;
    in_data = '0;
    out_ready = 1'b1;
    model_reset();
    #3;
    chk("reset_in_ready", 32'(in_ready), 32'h00);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_sel", 32'(out_sel), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_data();
    #1;
    chk("first_grant", 32'(in_ready), 32'h01);
    step();
    in_valid = '0;
    step();

    // Single channel beat, then the grant table from ptr=0.
    do_reset();
    in_valid = 8'h20;
    rand_data();
    in_data[5*8 +: 8] = 8'hA5;
    step();
    in_valid = '0;
    #1;
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_sel", 32'(out_sel), 32'd5);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = vecs[i].valid;
      rand_data();
      #1;
      chk($sformatf("table_rdy[%0d]", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      step();
    end
    in_valid = '0;
    step();

    // All channels valid: one beat per cycle in order 0..7,0.
    do_reset();
    in_valid = 8'hFF;
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'(k);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("all_rdy[%0d]", i), 32'(in_ready), 32'(8'h01 << (i % 8)));
      step();
    end
    in_valid = '0;
    step();

    // Backpressure on a beat from channel 2.
    do_reset();
    in_valid = 8'h04;
    rand_data();
    step();
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step();
      chk("bp_sel", 32'(out_sel), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'h08);
    step();
    in_valid = '0;
    step();
    step();

    // Pointer wrap 7 -> 0 -> 1.
    do_reset();
    in_valid = 8'h40;
    rand_data();
    step();
    in_valid = 8'h81;
    #1;
    chk("wrap_g7", 32'(in_ready), 32'h80);
    step();
    #1;
    chk("wrap_g0", 32'(in_ready), 32'h01);
    step();
    #1;
    chk("wrap_ptr1", 32'(in_ready), 32'h80);
    step();
    in_valid = '0;
    step();

    // Asynchronous reset while a beat is pending.
    do_reset();
    in_valid = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h00);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    in_valid = '0;
    step();
    in_valid = 8'hFF;
    #1;
    chk("post_rst_grant", 32'(in_ready), 32'h01);
    step();
    in_valid = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
